// File: rtl/mem_pkg.sv
`default_nettype none
//============================================================================
// Module      : mem_pkg
// Description : Shared types and constants for the block memory responder:
//               default widths, read/write encoding, controller state
//               encoding and the block-offset width helper.
// Revision    : 1.0 - initial release
//============================================================================
package mem_pkg;

    // Default geometry of the main-memory side
    localparam int unsigned c_ADDR_W = 10;
    localparam int unsigned c_DATA_W = 32;

    // Direction encoding carried on read_write_mem
    localparam logic c_MEM_READ  = 1'b0;
    localparam logic c_MEM_WRITE = 1'b1;

    // Controller state encoding
    localparam int unsigned c_STATE_W = 2;
    typedef logic [c_STATE_W-1:0] state_t;
    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_WAIT = 2'd1;
    localparam state_t c_ST_XFER = 2'd2;
    localparam state_t c_ST_DONE = 2'd3;

    // Number of bits needed to index a word inside a block
    function automatic int unsigned blk_off_w(input int unsigned words);
        return (words < 2) ? 1 : $clog2(words);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_word_array.sv
`default_nettype none
//============================================================================
// Module      : mem_word_array
// Description : Single-port word storage with synchronous write and a
//               registered read port. The read register holds its value
//               unless a read is enabled; a read may be forced to return
//               zero. Storage contents start at zero and survive reset.
// Revision    : 1.0 - initial release
//============================================================================
module mem_word_array #(
    parameter int unsigned AW     = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     i_addr,
    input  logic              i_we,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic              i_rclr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DATA_W-1:0] r_mem [0:DEPTH-1] = '{default: '0};
    logic [DATA_W-1:0] r_rdata;

    // Storage write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Registered read data, held between enabled reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= i_rclr ? '0 : r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/block_mem_responder.sv
`default_nettype none
//============================================================================
// Module      : block_mem_responder
// Description : Main-memory responder for a write-back cache. Accepts a
//               whole-block read or write, waits LATENCY cycles, moves one
//               word per cycle, then pulses done for one cycle.
//               Optional macro MEM_ALIGN_CHECK_EN adds an err output that
//               flags requests whose byte address is not word aligned;
//               such requests keep their timing but write nothing and
//               read zeros.
// Revision    : 1.0 - initial release
//============================================================================
module block_mem_responder
    import mem_pkg::*;
#(
    parameter  int unsigned ADDR_W      = c_ADDR_W,
    parameter  int unsigned DATA_W      = c_DATA_W,
    parameter  int unsigned BLOCK_WORDS = 4,
    parameter  int unsigned LATENCY     = 4,
    localparam int unsigned IDX_W       = blk_off_w(BLOCK_WORDS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              read_write_mem,
    input  logic [ADDR_W-1:0] address_mem,
    input  logic [DATA_W-1:0] write_data_mem,
    output logic [DATA_W-1:0] read_data_mem,
    output logic              word_valid,
    output logic              word_ready,
    output logic [IDX_W-1:0]  word_idx,
    output logic              busy,
    output logic              done
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic              err
`endif
);

    localparam int unsigned WORD_AW = ADDR_W - 2;
    localparam int unsigned HI_W    = WORD_AW - IDX_W;
    localparam int unsigned CNT_W   = $clog2(LATENCY) + 1;

    localparam logic [IDX_W-1:0] c_LAST_IDX  = IDX_W'(BLOCK_WORDS - 1);
    localparam logic [CNT_W-1:0] c_WAIT_LOAD = CNT_W'(LATENCY - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_rw;
    logic [HI_W-1:0]    r_base_hi;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic               r_misalign;
    logic               w_wait_end;
    logic               w_rd_en;
    logic               w_we;
    logic               w_rd_clr;
    logic [IDX_W-1:0]   w_rd_idx;
    logic [WORD_AW-1:0] w_mem_addr;
    logic               w_unused_addr;

    // The in-block offset bits only select a word inside the block
    assign w_unused_addr = &{1'b0, address_mem[IDX_W+1:0]};

    assign w_wait_end = (r_state == c_ST_WAIT) && (r_wait_cnt == '0);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state selection and state-decoded outputs
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        word_valid  = 1'b0;
        word_ready  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (req) begin
                    w_state_nxt = c_ST_WAIT;
                end
            end
            c_ST_WAIT: begin
                busy = 1'b1;
                if (r_wait_cnt == '0) begin
                    w_state_nxt = c_ST_XFER;
                end
            end
            c_ST_XFER: begin
                busy       = 1'b1;
                word_valid = (r_rw == c_MEM_READ);
                word_ready = (r_rw == c_MEM_WRITE);
                if (r_idx == c_LAST_IDX) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Request capture, latency countdown and word index
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rw       <= c_MEM_READ;
            r_base_hi  <= '0;
            r_wait_cnt <= '0;
            r_idx      <= '0;
            r_misalign <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (req) begin
                        r_rw       <= read_write_mem;
                        r_base_hi  <= address_mem[ADDR_W-1 -: HI_W];
                        r_wait_cnt <= c_WAIT_LOAD;
                        r_idx      <= '0;
`ifdef MEM_ALIGN_CHECK_EN
                        r_misalign <= |address_mem[1:0];
`else
                        r_misalign <= 1'b0;
`endif
                    end
                end
                c_ST_WAIT: begin
                    if (r_wait_cnt != '0) begin
                        r_wait_cnt <= r_wait_cnt - CNT_W'(1);
                    end
                end
                c_ST_XFER: begin
                    // Wraps back to zero after the last word
                    r_idx <= r_idx + IDX_W'(1);
                end
                default: begin
                    r_idx <= r_idx;
                end
            endcase
        end
    end

    // Reads are prefetched on the edge that enters each word's cycle, so the
    // read port addresses the next word; writes address the current word.
    assign w_rd_idx   = (r_state == c_ST_WAIT) ? '0 : (r_idx + IDX_W'(1));
    assign w_rd_en    = (r_rw == c_MEM_READ) &&
                        (w_wait_end || ((r_state == c_ST_XFER) && (r_idx != c_LAST_IDX)));
    assign w_we       = (r_state == c_ST_XFER) && (r_rw == c_MEM_WRITE) && !r_misalign;
    assign w_rd_clr   = r_misalign;
    assign w_mem_addr = {r_base_hi, (r_rw == c_MEM_WRITE) ? r_idx : w_rd_idx};
    assign word_idx   = r_idx;

`ifdef MEM_ALIGN_CHECK_EN
    assign err = done & r_misalign;
`endif

    mem_word_array #(
        .AW     (WORD_AW),
        .DATA_W (DATA_W)
    ) u_array (
        .clk     (clock),
        .rst     (reset),
        .i_addr  (w_mem_addr),
        .i_we    (w_we),
        .i_wdata (write_data_mem),
        .i_re    (w_rd_en),
        .i_rclr  (w_rd_clr),
        .o_rdata (read_data_mem)
    );

endmodule
`default_nettype wire

// File: tb/tb_block_mem_responder.sv
`default_nettype none
//============================================================================
// Module      : tb_block_mem_responder
// Description : Self-checking bench for block_mem_responder. A transaction
//               level model predicts every output from the request timing
//               rules; directed block operations pin literal values, then
//               randomized requests, addresses, data and resets follow.
// Revision    : 1.0 - initial release
//============================================================================
module tb_block_mem_responder;

    localparam int LAT = 4;
    localparam int BW  = 4;

    logic        clk;
    logic        rst;
    logic        req;
    logic        read_write_mem;
    logic [9:0]  address_mem;
    logic [31:0] write_data_mem;
    logic [31:0] read_data_mem;
    logic        word_valid;
    logic        word_ready;
    logic [1:0]  word_idx;
    logic        busy;
    logic        done;
`ifdef MEM_ALIGN_CHECK_EN
    logic        err;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Stimulus-side write data selection
    bit          wd_mode = 1'b0;
    logic [31:0] wd_base = '0;

    // Behavioural model state
    logic [31:0] mdl_mem [0:255];
    int          cyc    = 0;
    int          t0     = 0;
    bit          active = 1'b0;
    bit          m_rw   = 1'b0;
    bit          m_mis  = 1'b0;
    int          m_word = 0;
    bit          e_busy = 1'b0;
    bit          e_done = 1'b0;
    bit          e_valid = 1'b0;
    bit          e_ready = 1'b0;
    bit          e_err  = 1'b0;
    logic [1:0]  e_idx  = '0;
    logic [31:0] e_rdata = '0;

    block_mem_responder dut (
        .clock          (clk),
        .reset          (rst),
        .req            (req),
        .read_write_mem (read_write_mem),
        .address_mem    (address_mem),
        .write_data_mem (write_data_mem),
        .read_data_mem  (read_data_mem),
        .word_valid     (word_valid),
        .word_ready     (word_ready),
        .word_idx       (word_idx),
        .busy           (busy),
        .done           (done)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .err            (err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: outputs follow from cycles elapsed since acceptance
    initial begin : model
        int p;
        for (int i = 0; i < 256; i++) mdl_mem[i] = '0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                active  = 1'b0;
                e_busy  = 1'b0;
                e_done  = 1'b0;
                e_valid = 1'b0;
                e_ready = 1'b0;
                e_err   = 1'b0;
                e_idx   = '0;
                e_rdata = '0;
            end else begin
                if (e_ready && !m_mis) mdl_mem[m_word + int'(e_idx)] = write_data_mem;
                if (!e_busy && req) begin
                    active = 1'b1;
                    t0     = cyc;
                    m_rw   = read_write_mem;
                    m_word = (int'(address_mem) / 16) * 4;
`ifdef MEM_ALIGN_CHECK_EN
                    m_mis  = (int'(address_mem) % 4) != 0;
`else
                    m_mis  = 1'b0;
`endif
                end
                e_busy  = 1'b0;
                e_done  = 1'b0;
                e_valid = 1'b0;
                e_ready = 1'b0;
                e_err   = 1'b0;
                if (active) begin
                    p = cyc - t0;
                    if (p <= LAT + BW) e_busy = 1'b1;
                    else active = 1'b0;
                    if (p >= LAT && p < LAT + BW) begin
                        e_idx   = 2'(p - LAT);
                        e_valid = !m_rw;
                        e_ready = m_rw;
                        if (!m_rw) e_rdata = m_mis ? '0 : mdl_mem[m_word + int'(e_idx)];
                    end
                    if (p == LAT + BW) begin
                        e_done = 1'b1;
                        e_err  = m_mis;
                    end
                end
                cyc++;
            end
        end
    end

    // Per-cycle comparison against the model, then drive this cycle's write word
    initial begin : cmp
        write_data_mem = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("ctl", 64'({busy, done, word_valid, word_ready}),
                    64'({e_busy, e_done, e_valid, e_ready}));
                chk("rdata", 64'(read_data_mem), 64'(e_rdata));
                if (e_valid || e_ready) chk("idx", 64'(word_idx), 64'(e_idx));
`ifdef MEM_ALIGN_CHECK_EN
                chk("err", 64'(err), 64'(e_err));
`endif
            end
            write_data_mem = wd_mode ? (wd_base + 32'(e_idx)) : $urandom;
        end
    end

    // One block operation with literal per-cycle expectations (cycle 0 follows acceptance)
    task automatic run_op(input string nm, input logic rw, input logic [9:0] addr,
                          input logic [127:0] exp_rd, input int last_c);
        logic [9:0] busy_m;
        logic [9:0] xfer_m;
        logic [9:0] done_m;
        busy_m = 10'b01_1111_1111;
        xfer_m = 10'b00_1111_0000;
        done_m = 10'b01_0000_0000;
        @(negedge clk);
        req            = 1'b1;
        read_write_mem = rw;
        address_mem    = addr;
        for (int c = 0; c <= last_c; c++) begin
            @(negedge clk);
            if (c == 0) req = 1'b0;
            chk({nm, "_busy"},  64'(busy),       64'(busy_m[c]));
            chk({nm, "_done"},  64'(done),       64'(done_m[c]));
            chk({nm, "_valid"}, 64'(word_valid), 64'(xfer_m[c] & ~rw));
            chk({nm, "_ready"}, 64'(word_ready), 64'(xfer_m[c] & rw));
            if (xfer_m[c]) begin
                chk({nm, "_idx"}, 64'(word_idx), 64'(c - 4));
                if (!rw) chk({nm, "_data"}, 64'(read_data_mem), 64'(exp_rd[32*(c-4) +: 32]));
            end
        end
    endtask

    function automatic logic [9:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 10'h3C0 + 10'($urandom_range(0, 63));
        return 10'($urandom_range(0, 127));
    endfunction

    initial begin : stim
        logic [10:0] hold_busy_m;
        logic [10:0] hold_xfer_m;
        rst            = 1'b1;
        req            = 1'b0;
        read_write_mem = 1'b0;
        address_mem    = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_ctl",   64'({busy, done, word_valid, word_ready, word_idx}), 64'(0));
        chk("reset_rdata", 64'(read_data_mem), 64'(0));

        // Write 0xA0..0xA3 to block 0x040, read it back from an offset address
        wd_mode = 1'b1;
        wd_base = 32'hA0;
        run_op("wrA", 1'b1, 10'h040, 128'h0, 9);
        run_op("rdA", 1'b0, 10'h048, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 9);

        // req held high: one transfer, next acceptance on the first idle edge
        hold_busy_m = 11'b101_1111_1111;
        hold_xfer_m = 11'b000_1111_0000;
        @(negedge clk);
        req            = 1'b1;
        read_write_mem = 1'b0;
        address_mem    = 10'h040;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            chk("hold_busy",  64'(busy),       64'(hold_busy_m[c]));
            chk("hold_valid", 64'(word_valid), 64'(hold_xfer_m[c]));
        end
        req = 1'b0;
        repeat (12) @(negedge clk);

        // Reset after the second written word: words 0,1 land, 2,3 untouched
        wd_base = 32'hB0;
        run_op("wrB", 1'b1, 10'h040, 128'h0, 6);
        #1 rst = 1'b1;
        #1;
        chk("midrst_ctl",   64'({busy, done, word_valid, word_ready, word_idx}), 64'(0));
        chk("midrst_rdata", 64'(read_data_mem), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("midrst_nodone", 64'({busy, done}), 64'(0));
        end
        run_op("rdB", 1'b0, 10'h040, {32'hA3, 32'hA2, 32'hB1, 32'hB0}, 9);

        // Top block: no wrap to address zero
        wd_base = 32'hC0;
        run_op("wrTop", 1'b1, 10'h3F0, 128'h0, 9);
        run_op("rdTop", 1'b0, 10'h3FC, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 9);
        run_op("rdZero", 1'b0, 10'h000, 128'h0, 9);

        // Randomized traffic with occasional mid-cycle resets
        wd_mode = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            req            = ($urandom_range(0, 2) == 0);
            read_write_mem = 1'($urandom_range(0, 1));
            address_mem    = rand_addr();
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 1'b1;
                #1;
                chk("rnd_rst", 64'({busy, done, word_valid, word_ready, read_data_mem}), 64'(0));
                @(negedge clk);
                rst = 1'b0;
            end
        end
        req = 1'b0;
        repeat (15) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/block_mem_responder.md
Name: block_mem_responder

Overview:
- Clocked main-memory responder on the cache-to-main-memory side of the cache hierarchy.
- Services whole-block read (refill) and write (write-back) requests from a direct-mapped write-back cache.
- Each request sees a programmable access latency, then moves one word per cycle, then a one-cycle done pulse.
- Stands in for the zero-time memory model when the cache controller must be exercised against real multi-cycle latency.

Parameters:
- ADDR_W, 10, byte-address width.
- DATA_W, 32, word width.
- BLOCK_WORDS, 4, words per block; power of two, at least 2.
- LATENCY, 4, wait cycles before the first word; at least 1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  request strobe; sampled only in IDLE.
- read_write_mem  in  1  1 = write block, 0 = read block; latched with req.
- address_mem  in  ADDR_W  byte address, any word of the block.
- write_data_mem  in  DATA_W  write word; must hold word word_idx while word_ready=1.
- read_data_mem  out  DATA_W  read word, valid when word_valid=1.
- word_valid  out  1  read word present this cycle.
- word_ready  out  1  write word consumed at the end of this cycle.
- word_idx  out  log2(BLOCK_WORDS)  index of the current word within the block.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Storage: 2^(ADDR_W-2) words, word-addressed by address_mem[ADDR_W-1:2]. Contents are zero at simulation start. Reset does not alter contents.
- Reset values: all outputs 0, state IDLE, internal counters 0.
- Block base: address_mem with the low log2(BLOCK_WORDS)+2 bits cleared, latched at acceptance. Word i is at base+4i. Transfers never cross a block boundary and never wrap the address space.
- State IDLE:
  - If req=1 at the clock edge, latch rw and base, load wait counter with LATENCY-1, go to WAIT.
  - If req=0, stay in IDLE.
- State WAIT:
  - Decrement the wait counter each edge.
  - At counter==0, go to XFER with word_idx=0.
  - WAIT lasts exactly LATENCY cycles.
- State XFER, BLOCK_WORDS cycles, word_idx 0..BLOCK_WORDS-1:
  - Read: read_data_mem = mem[base+word_idx], registered (fetched on the entering edge); word_valid=1.
  - Write: word_ready=1; write_data_mem is written to mem[base+word_idx] on the closing edge.
  - After the last word, go to DONE.
- State DONE: done=1 for one cycle, busy=1, then IDLE. word_valid and word_ready are 0.
- Total latency: req accepted at edge E0; first word in cycle E0+LATENCY; done in cycle E0+LATENCY+BLOCK_WORDS.
- req while busy, including during DONE, is ignored and not queued. The earliest next acceptance is the first IDLE cycle.
- Inputs other than req and write_data_mem are ignored after acceptance.
- read_data_mem holds its last value outside XFER reads.
- Reset mid-operation: return to IDLE at once. Words already written stay written; remaining words are untouched; no done pulse.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- With it defined:
  - Extra output err (1 bit, reset 0).
  - A request with address_mem[1:0] != 0 is still accepted and timed identically.
  - Writes are suppressed; read words return 0.
  - err pulses together with done.
- Without it: no err port; the low two address bits are ignored.

Decomposition:
- Shared package mem_pkg:
  - state enum (IDLE, WAIT, XFER, DONE);
  - default ADDR_W and DATA_W;
  - read/write encoding constants (MEM_READ=0, MEM_WRITE=1);
  - block-offset width function.
- Sub-module mem_word_array: synchronous-write, registered-read storage with a single port. The FSM and counters stay in block_mem_responder.

Test Plan:
- Reset: assert reset mid-cycle -> all outputs 0 asynchronously, busy=0, state IDLE.
- Write block: req at E0, rw=1, addr 0x040, data 0xA0..0xA3 by word_idx -> word_ready in cycles 4..7 with word_idx 0..3, done in cycle 8, busy falls in cycle 9.
- Read-back unaligned: req rw=0, addr 0x048 -> base 0x040; word_valid in cycles 4..7 with data 0xA0,0xA1,0xA2,0xA3; done in cycle 8.
- req held high across a whole read -> exactly one transfer; a second request is accepted only on the first IDLE edge after done.
- Reset after the second word_ready of a write of 0xB0..0xB3 to 0x040 -> reading back gives 0xB0,0xB1,0xA2,0xA3; no done pulse.
- Top block: read addr 0x3FC -> base 0x3F0, words 0x3F0..0x3FC returned, no address wrap to 0x000.
